// File: rtl/slave_port_arbiter.sv
`timescale 1ns/1ps
// slave_port_arbiter: round-robin owner of a single slave port. Runs one complete
// req/ack/resp transaction at a time, with a bounded wait and timeout error completion.
module slave_port_arbiter #(
    parameter int MASTERS = 4,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255,
    localparam int GW = $clog2(MASTERS),
    localparam int CW = $clog2(TIMEOUT + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [MASTERS-1:0]        m_req,
    input  logic [MASTERS-1:0]        m_cmd,
    input  logic [MASTERS*ADDR_W-1:0] m_addr,
    input  logic [MASTERS*32-1:0]     m_wdata,
    output logic [MASTERS-1:0]        m_ack,
    output logic [MASTERS-1:0]        m_resp,
    output logic [MASTERS-1:0]        m_err,
    output logic [31:0]               m_rdata,
    output logic                      s_req,
    output logic                      s_cmd,
    output logic [ADDR_W-1:0]         s_addr,
    output logic [31:0]               s_wdata,
    input  logic                      s_ack,
    input  logic                      s_resp,
    input  logic [31:0]               s_rdata,
    output logic                      busy,
    output logic [GW-1:0]             grant_id,
    output logic [1:0]                dbg_state
);

    // Handshake: m_req is a level held stable (with cmd/addr/wdata) until m_ack;
    // every other strobe (s_req, s_ack, s_resp, m_ack, m_resp, m_err) is a one-cycle pulse.
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_ACK  = 2'd1;
    localparam logic [1:0] ST_WAIT_RESP = 2'd2;
    localparam logic [1:0] ST_GAP       = 2'd3;

    logic [1:0]         state;
    logic [GW-1:0]      ptr;
    logic [GW-1:0]      winner;
    logic [CW-1:0]      cnt;
    logic [MASTERS-1:0] owner_oh;
    logic               timed_out;

    // Scan offsets from farthest to nearest so the first requester after ptr ends up winning.
    always_comb begin
        winner = ptr;
        for (int i = MASTERS; i >= 1; i--) begin
            if (m_req[GW'(ptr + GW'(i))]) begin
                winner = ptr + GW'(i);
            end
        end
    end

    assign owner_oh  = {{(MASTERS-1){1'b0}}, 1'b1} << grant_id;
    assign timed_out = (cnt == CW'(TIMEOUT));
    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            ptr      <= {GW{1'b1}};
            cnt      <= '0;
            grant_id <= '0;
            m_ack    <= '0;
            m_resp   <= '0;
            m_err    <= '0;
            m_rdata  <= '0;
            s_req    <= 1'b0;
            s_cmd    <= 1'b0;
            s_addr   <= '0;
            s_wdata  <= '0;
        end else begin
            m_ack   <= '0;
            m_resp  <= '0;
            m_err   <= '0;
            m_rdata <= '0;
            s_req   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|m_req) begin
                        s_req    <= 1'b1;
                        s_cmd    <= m_cmd[winner];
                        s_addr   <= m_addr[winner*ADDR_W +: ADDR_W];
                        s_wdata  <= m_wdata[winner*32 +: 32];
                        grant_id <= winner;
                        ptr      <= winner;
                        cnt      <= '0;
                        state    <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    // The expected event beats a timeout landing in the same cycle.
                    if (s_ack) begin
                        m_ack <= owner_oh;
                        if (s_cmd) begin
                            state <= ST_GAP;
                        end else if (s_resp) begin
                            m_resp  <= owner_oh;
                            m_rdata <= s_rdata;
                            state   <= ST_GAP;
                        end else begin
                            cnt   <= '0;
                            state <= ST_WAIT_RESP;
                        end
                    end else if (timed_out) begin
                        m_ack <= owner_oh;
                        m_err <= owner_oh;
                        state <= ST_GAP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_WAIT_RESP: begin
                    if (s_resp) begin
                        m_resp  <= owner_oh;
                        m_rdata <= s_rdata;
                        state   <= ST_GAP;
                    end else if (timed_out) begin
                        m_resp <= owner_oh;
                        m_err  <= owner_oh;
                        state  <= ST_GAP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_GAP: begin
                    // Owner drops m_req here; skipping arbitration keeps it from being re-granted.
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slave_port_arbiter.sv
`timescale 1ns/1ps
// tb_slave_port_arbiter: scenario tasks with a transaction-level model of the
// round-robin choice, slave timing and timeout behaviour.
module tb_slave_port_arbiter;

    localparam int MASTERS = 4;
    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 8;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [MASTERS-1:0]        m_req = '0;
    logic [MASTERS-1:0]        m_cmd = '0;
    logic [MASTERS*ADDR_W-1:0] m_addr = '0;
    logic [MASTERS*32-1:0]     m_wdata = '0;
    logic [MASTERS-1:0]        m_ack, m_resp, m_err;
    logic [31:0]               m_rdata;
    logic                      s_req, s_cmd;
    logic [ADDR_W-1:0]         s_addr;
    logic [31:0]               s_wdata;
    logic                      s_ack = 1'b0;
    logic                      s_resp = 1'b0;
    logic [31:0]               s_rdata = '0;
    logic                      busy;
    logic [1:0]                grant_id;
    logic [1:0]                dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ptr_m = MASTERS - 1;
    logic        req_cmd   [MASTERS];
    logic [31:0] req_addr  [MASTERS];
    logic [31:0] req_wdata [MASTERS];

    slave_port_arbiter #(.MASTERS(MASTERS), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .m_req(m_req), .m_cmd(m_cmd), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_resp(m_resp), .m_err(m_err), .m_rdata(m_rdata),
        .s_req(s_req), .s_cmd(s_cmd), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_ack(s_ack), .s_resp(s_resp), .s_rdata(s_rdata),
        .busy(busy), .grant_id(grant_id), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- drivers ----------------
    task automatic set_master(input int i, input logic cmd, input logic [31:0] addr,
                              input logic [31:0] wdata);
        req_cmd[i]   = cmd;
        req_addr[i]  = addr;
        req_wdata[i] = wdata;
        m_cmd[i]     = cmd;
        m_addr[i*ADDR_W +: ADDR_W] = addr;
        m_wdata[i*32 +: 32]        = wdata;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        ptr_m = MASTERS - 1;
    endtask

    // Reference: first requester after the last owner, wrapping modulo MASTERS.
    function automatic int pick(input int p, input logic [MASTERS-1:0] r);
        for (int d = 1; d <= MASTERS; d++) begin
            if (r[(p + d) % MASTERS]) return (p + d) % MASTERS;
        end
        return -1;
    endfunction

    // One transaction with a scripted slave, starting in IDLE, ending in the IDLE after GAP.
    // ack_d: cycles after s_req at which s_ack is driven (<0 never).
    // resp_d: cycles after the m_ack cycle at which s_resp is driven; -1 with s_ack, -2 never.
    task automatic do_txn(input int ack_d, input int resp_d, input logic [31:0] rd,
                          input bit release_req, input int exp_wait, output int sreq_cyc);
        int g, n, exp_c;
        bit is_rd;
        logic [MASTERS-1:0] oh, exp_resp, exp_err;
        logic [31:0] exp_rdata;
        sreq_cyc = -1;
        g = pick(ptr_m, m_req);
        checks++;
        if (g < 0) begin
            errors++;
            $display("FAIL txn_setup: no pending request, m_req=%b", m_req);
            return;
        end
        oh = 4'b0001 << g;
        is_rd = (req_cmd[g] == 1'b0);
        n = 0;
        while (s_req !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (s_req !== 1'b1) begin
            errors++;
            $display("FAIL s_req_wait: no s_req after %0d cycles", n);
            return;
        end
        sreq_cyc = cyc;
        if (exp_wait >= 0) begin
            checks++;
            if (n !== exp_wait) begin
                errors++;
                $display("FAIL s_req_latency: got %0d cycles, expected %0d", n, exp_wait);
            end
        end
        checks++;
        if (grant_id !== 2'(g)) begin
            errors++;
            $display("FAIL grant_id: got %0d, expected %0d", grant_id, g);
        end
        checks++;
        if ({s_cmd, s_addr, s_wdata} !== {req_cmd[g], req_addr[g], req_wdata[g]} || busy !== 1'b1) begin
            errors++;
            $display("FAIL s_fields: got cmd=%b addr=%h wdata=%h busy=%b, expected cmd=%b addr=%h wdata=%h busy=1",
                     s_cmd, s_addr, s_wdata, busy, req_cmd[g], req_addr[g], req_wdata[g]);
        end
        ptr_m = g;

        exp_c = (ack_d < 0) ? TIMEOUT + 1 : ack_d + 1;
        for (int c = 1; c <= exp_c; c++) begin
            step();
            s_ack = 1'b0;
            s_resp = 1'b0;
            if (c < exp_c) begin
                checks++;
                if ({m_ack, m_resp, m_err, s_req} !== '0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL ack_wait c=%0d: got ack=%b resp=%b err=%b s_req=%b busy=%b, expected quiet and busy",
                             c, m_ack, m_resp, m_err, s_req, busy);
                end
            end
            if (c == ack_d) begin
                s_ack = 1'b1;
                if (resp_d == -1) begin
                    s_resp = 1'b1;
                    s_rdata = rd;
                end
            end else if (c == 1) begin
                s_resp = 1'b1;
                s_rdata = $urandom();
            end
        end
        exp_resp  = (ack_d >= 0 && resp_d == -1 && is_rd) ? oh : 4'b0000;
        exp_rdata = (exp_resp != 4'b0000) ? rd : 32'h0;
        exp_err   = (ack_d < 0) ? oh : 4'b0000;
        checks++;
        if (m_ack !== oh || m_err !== exp_err || m_resp !== exp_resp || m_rdata !== exp_rdata) begin
            errors++;
            $display("FAIL ack_phase: got ack=%b err=%b resp=%b rdata=%h, expected ack=%b err=%b resp=%b rdata=%h",
                     m_ack, m_err, m_resp, m_rdata, oh, exp_err, exp_resp, exp_rdata);
        end
        if (release_req) m_req[g] = 1'b0;

        if (is_rd && ack_d >= 0 && resp_d != -1) begin
            exp_c = (resp_d < 0) ? TIMEOUT + 1 : resp_d + 1;
            if (resp_d == 0) begin
                s_resp = 1'b1;
                s_rdata = rd;
            end else begin
                s_ack = 1'b1;
            end
            for (int c = 1; c <= exp_c; c++) begin
                step();
                s_ack = 1'b0;
                s_resp = 1'b0;
                s_rdata = $urandom();
                if (c < exp_c) begin
                    checks++;
                    if ({m_ack, m_resp, m_err} !== '0 || busy !== 1'b1) begin
                        errors++;
                        $display("FAIL resp_wait c=%0d: got ack=%b resp=%b err=%b busy=%b, expected quiet and busy",
                                 c, m_ack, m_resp, m_err, busy);
                    end
                end
                if (c == resp_d) begin
                    s_resp = 1'b1;
                    s_rdata = rd;
                end
            end
            exp_err   = (resp_d < 0) ? oh : 4'b0000;
            exp_rdata = (resp_d < 0) ? 32'h0 : rd;
            checks++;
            if (m_resp !== oh || m_ack !== 4'b0000 || m_err !== exp_err || m_rdata !== exp_rdata) begin
                errors++;
                $display("FAIL resp_phase: got resp=%b ack=%b err=%b rdata=%h, expected resp=%b ack=0000 err=%b rdata=%h",
                         m_resp, m_ack, m_err, m_rdata, oh, exp_err, exp_rdata);
            end
        end

        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL gap_busy: got %b, expected 1", busy);
        end
        if ($urandom_range(0, 1) == 1 || ack_d < 0 || resp_d == -2) begin
            s_ack = 1'b1;
            s_resp = 1'b1;
            s_rdata = $urandom();
        end
        step();
        s_ack = 1'b0;
        s_resp = 1'b0;
        checks++;
        if ({m_ack, m_resp, m_err, s_req} !== '0 || busy !== 1'b0 || m_rdata !== 32'h0) begin
            errors++;
            $display("FAIL idle_after_gap: got ack=%b resp=%b err=%b s_req=%b busy=%b rdata=%h, expected all 0",
                     m_ack, m_resp, m_err, s_req, busy, m_rdata);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        m_req = '0;
        apply_reset();
        checks++;
        if ({m_ack, m_resp, m_err, m_rdata, s_req, s_cmd, s_addr, s_wdata, busy, grant_id} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ack=%b resp=%b err=%b rdata=%h s_req=%b cmd=%b addr=%h wdata=%h busy=%b gid=%0d, expected all 0",
                     m_ack, m_resp, m_err, m_rdata, s_req, s_cmd, s_addr, s_wdata, busy, grant_id);
        end
    endtask

    task automatic test_single_write();
        int sc;
        m_req = '0;
        set_master(2, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF);
        m_req[2] = 1'b1;
        do_txn(2, -2, 32'h0, 1'b1, 1, sc);
    endtask

    task automatic test_single_read();
        int sc;
        m_req = '0;
        set_master(1, 1'b0, $urandom(), $urandom());
        m_req[1] = 1'b1;
        do_txn(1, 2, 32'h1234_5678, 1'b1, 1, sc);
    endtask

    task automatic test_fairness();
        int sc, prev;
        m_req = '0;
        for (int i = 0; i < MASTERS; i++) set_master(i, 1'b1, $urandom(), $urandom());
        m_req = '1;
        apply_reset();
        prev = -1;
        for (int k = 0; k < 2 * MASTERS; k++) begin
            checks++;
            if (pick(ptr_m, m_req) !== k % MASTERS) begin
                errors++;
                $display("FAIL fairness_order: model pick %0d, expected %0d", pick(ptr_m, m_req), k % MASTERS);
            end
            do_txn(1, -2, 32'h0, 1'b0, 1, sc);
            if (prev >= 0) begin
                checks++;
                if (sc - prev !== 4) begin
                    errors++;
                    $display("FAIL back_to_back_period: got %0d cycles, expected 4", sc - prev);
                end
            end
            prev = sc;
        end
        m_req = '0;
    endtask

    task automatic test_timeout();
        int sc;
        m_req = '0;
        set_master(3, 1'b1, $urandom(), $urandom());
        m_req[3] = 1'b1;
        do_txn(-1, -2, 32'h0, 1'b1, 1, sc);
        set_master(3, 1'b0, $urandom(), $urandom());
        m_req[3] = 1'b1;
        do_txn(1, -2, 32'h0, 1'b1, 1, sc);
        set_master(3, 1'b0, $urandom(), $urandom());
        m_req[3] = 1'b1;
        do_txn(-1, 0, 32'hFFFF_FFFF, 1'b1, 1, sc);
    endtask

    task automatic test_edges();
        int sc;
        m_req = '0;
        set_master(0, 1'b0, $urandom(), $urandom());
        m_req[0] = 1'b1;
        do_txn(1, -1, 32'hA5A5_0001, 1'b1, 1, sc);
        set_master(1, 1'b0, $urandom(), $urandom());
        m_req[1] = 1'b1;
        do_txn(TIMEOUT, TIMEOUT, 32'hC0DE_0002, 1'b1, 1, sc);
        set_master(2, 1'b1, $urandom(), $urandom());
        m_req[2] = 1'b1;
        do_txn(TIMEOUT, -2, 32'h0, 1'b1, 1, sc);
    endtask

    task automatic test_random();
        int sc, ad, rdl, r;
        logic [MASTERS-1:0] add;
        m_req = '0;
        for (int k = 0; k < 24; k++) begin
            add = 4'($urandom_range(1, 15));
            for (int i = 0; i < MASTERS; i++) begin
                if (add[i] && !m_req[i]) begin
                    set_master(i, 1'($urandom_range(0, 1)), $urandom(), $urandom());
                    m_req[i] = 1'b1;
                end
            end
            r = $urandom_range(0, 9);
            ad = (r == 0) ? -1 : (r % 4) + 1;
            r = $urandom_range(0, 9);
            rdl = (r == 0) ? -2 : (r == 1) ? -1 : r % 4;
            do_txn(ad, rdl, $urandom(), 1'($urandom_range(0, 1)), 1, sc);
        end
        m_req = '0;
    endtask

    task automatic test_reset_mid();
        int n, sc;
        bit stray;
        m_req = '0;
        set_master(2, 1'b0, $urandom(), $urandom());
        m_req[2] = 1'b1;
        n = 0;
        while (s_req !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        s_ack = 1'b1;
        step();
        s_ack = 1'b0;
        m_req[2] = 1'b0;
        checks++;
        if (m_ack !== 4'b0100) begin
            errors++;
            $display("FAIL mid_reset_ack: got %b, expected 0100", m_ack);
        end
        step();
        rst = 1'b1;
        s_resp = 1'b1;
        s_rdata = 32'hBAD0_BAD0;
        step();
        rst = 1'b0;
        s_resp = 1'b0;
        ptr_m = MASTERS - 1;
        checks++;
        if ({m_ack, m_resp, m_err, m_rdata, s_req, s_cmd, s_addr, s_wdata, busy, grant_id} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got ack=%b resp=%b err=%b rdata=%h s_req=%b busy=%b gid=%0d, expected all 0",
                     m_ack, m_resp, m_err, m_rdata, s_req, busy, grant_id);
        end
        stray = 1'b0;
        for (int c = 0; c < TIMEOUT + 4; c++) begin
            s_resp = 1'($urandom_range(0, 1));
            step();
            if ({m_ack, m_resp, m_err} !== '0 || busy !== 1'b0) stray = 1'b1;
        end
        s_resp = 1'b0;
        checks++;
        if (stray !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_quiet: got stray completion or busy after reset, expected none");
        end
        for (int i = 0; i < MASTERS; i++) set_master(i, 1'b1, $urandom(), $urandom());
        m_req = 4'b1101;
        do_txn(1, -2, 32'h0, 1'b1, 1, sc);
        m_req = '0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_fairness();
        test_timeout();
        test_edges();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
